// File: rtl/aux_mem_arbiter_pkg.sv
// Shared types for the auxiliary memory arbiter: arbitration states and default bus widths.
`ifndef RV_BIT_NUM
`define RV_BIT_NUM 32
`endif
`ifndef RV_BIT_NUM_DIVIV_NUM
`define RV_BIT_NUM_DIVIV_NUM 4
`endif

package aux_mem_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = `RV_BIT_NUM;
  localparam int unsigned KEEP_W_DEF = `RV_BIT_NUM_DIVIV_NUM;

  typedef enum logic [1:0] {
    CORE    = 2'd0,
    DRAIN   = 2'd1,
    AUX     = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/aux_mem_arbiter_if.sv
// Bus bundle between the core port, the auxiliary engine port and the data memory.
interface aux_mem_arbiter_if
  import aux_mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned KEEP_W = KEEP_W_DEF
);
  logic              core_mem_req;
  logic [KEEP_W-1:0] core_mem_keep;
  logic [DATA_W-1:0] core_mem_addr;
  logic [DATA_W-1:0] core_mem_datai;
  logic              core_mem_gnt;
  logic [DATA_W-1:0] core_mem_datao;
  logic              core_mem_rvalid;

  logic              aux_req;
  logic [DATA_W-1:0] aux_req_addr;
  logic              aux_busy;
  logic              aux_timeout;
  logic              aux_en;
  logic [DATA_W-1:0] aux_start_addr;
  logic              aux_done;
  logic [KEEP_W-1:0] aux_mem_keep;
  logic [DATA_W-1:0] aux_mem_datai;
  logic [DATA_W-1:0] aux_mem_addr;
  logic [DATA_W-1:0] aux_mem_datao;

  logic              mem_en;
  logic [KEEP_W-1:0] mem_keep;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_datai;
  logic [DATA_W-1:0] mem_datao;

  modport slave (
    input  core_mem_req, core_mem_keep, core_mem_addr, core_mem_datai,
    input  aux_req, aux_req_addr, aux_done, aux_mem_keep, aux_mem_datai, aux_mem_addr,
    input  mem_datao,
    output core_mem_gnt, core_mem_datao, core_mem_rvalid,
    output aux_busy, aux_timeout, aux_en, aux_start_addr, aux_mem_datao,
    output mem_en, mem_keep, mem_addr, mem_datai
  );

  modport master (
    output core_mem_req, core_mem_keep, core_mem_addr, core_mem_datai,
    output aux_req, aux_req_addr, aux_done, aux_mem_keep, aux_mem_datai, aux_mem_addr,
    output mem_datao,
    input  core_mem_gnt, core_mem_datao, core_mem_rvalid,
    input  aux_busy, aux_timeout, aux_en, aux_start_addr, aux_mem_datao,
    input  mem_en, mem_keep, mem_addr, mem_datai
  );
endinterface

// File: rtl/aux_mem_arbiter_aux_rd_tracker.sv
// Tracks in-flight core reads: a MEM_LAT-deep valid shift pipe with an empty flag.
module aux_rd_tracker #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic valid,
  output logic empty
);
  logic [MEM_LAT-1:0] pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= push;
      for (int unsigned i = 1; i < MEM_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign valid = pipe[MEM_LAT-1];
  assign empty = (pipe == '0);
endmodule

// File: rtl/aux_mem_arbiter.sv
// Hands the data memory from the core to the auxiliary engine for one session and back.
// Optional watchdog on the engine session: define AUX_ARB_TIMEOUT_EN.
module aux_mem_arbiter
  import aux_mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned KEEP_W      = KEEP_W_DEF,
  parameter int unsigned MEM_LAT     = 1,
  parameter int unsigned AUX_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  aux_mem_arbiter_if.slave bus
);
  localparam logic [KEEP_W-1:0] KEEP_RD = '0;

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("aux_mem_arbiter: MEM_LAT must be 1..4");
  end
  if (AUX_TIMEOUT < 2) begin : g_bad_tmo
    $error("aux_mem_arbiter: AUX_TIMEOUT must be at least 2");
  end

  arb_state_t        state, state_nx;
  logic              aux_req_q;
  logic              start;
  logic              aux_en_q;
  logic              busy_q;
  logic [DATA_W-1:0] start_addr_q;
  logic              rd_push;
  logic              rd_valid;
  logic              rd_empty;
  logic              tmo_hit;

  assign start = bus.aux_req & ~aux_req_q;

  // Edge history keeps sampling through reset so a request held across reset does not start a session.
  always_ff @(posedge clk) begin
    aux_req_q <= bus.aux_req;
    if (rst) begin
      state        <= CORE;
      aux_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      start_addr_q <= '0;
    end else begin
      state    <= state_nx;
      aux_en_q <= (state_nx == AUX);
      busy_q   <= (state_nx != CORE);
      if (state == CORE && start) begin
        start_addr_q <= bus.aux_req_addr;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      CORE:    if (start) state_nx = DRAIN;
      DRAIN:   if (rd_empty) state_nx = AUX;
      AUX:     if (bus.aux_done || tmo_hit) state_nx = RELEASE;
      RELEASE: state_nx = CORE;
      default: state_nx = CORE;
    endcase
  end

  always_comb begin
    bus.core_mem_gnt = 1'b0;
    bus.mem_en       = 1'b0;
    bus.mem_keep     = bus.core_mem_keep;
    bus.mem_addr     = bus.core_mem_addr;
    bus.mem_datai    = bus.core_mem_datai;
    case (state)
      CORE: begin
        bus.core_mem_gnt = bus.core_mem_req;
        bus.mem_en       = bus.core_mem_req;
      end
      AUX: begin
        bus.mem_en    = 1'b1;
        bus.mem_keep  = bus.aux_mem_keep;
        bus.mem_addr  = bus.aux_mem_addr;
        bus.mem_datai = bus.aux_mem_datai;
      end
      default: ;
    endcase
  end

`ifdef AUX_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(AUX_TIMEOUT);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_q;

  assign tmo_hit = (state == AUX) && !bus.aux_done &&
                   (tmo_cnt == TMO_W'(AUX_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || state != AUX) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
    tmo_q <= ~rst & tmo_hit;
  end

  assign bus.aux_timeout = tmo_q;
`else
  assign tmo_hit         = 1'b0;
  assign bus.aux_timeout = 1'b0;
`endif

  assign rd_push = bus.core_mem_gnt && (bus.core_mem_keep == KEEP_RD);

  aux_rd_tracker #(
    .MEM_LAT(MEM_LAT)
  ) u_rd_tracker (
    .clk  (clk),
    .rst  (rst),
    .push (rd_push),
    .valid(rd_valid),
    .empty(rd_empty)
  );

  assign bus.core_mem_rvalid = rd_valid;
  assign bus.core_mem_datao  = bus.mem_datao;
  assign bus.aux_mem_datao   = bus.mem_datao;
  assign bus.aux_en          = aux_en_q;
  assign bus.aux_busy        = busy_q;
  assign bus.aux_start_addr  = start_addr_q;
endmodule

// File: tb/tb_aux_mem_arbiter.sv
// Bench for aux_mem_arbiter: directed pins plus random traffic against a session/read-queue model.
module tb_aux_mem_arbiter;
  localparam int unsigned MEM_LAT     = 1;
  localparam int unsigned AUX_TIMEOUT = 16;
`ifdef AUX_ARB_TIMEOUT_EN
  localparam int unsigned DONE_ODDS = 40;
`else
  localparam int unsigned DONE_ODDS = 6;
`endif

  logic clk = 1'b0;
  logic rst;

  aux_mem_arbiter_if #(.DATA_W(32), .KEEP_W(4)) bus ();

  aux_mem_arbiter #(
    .DATA_W(32),
    .KEEP_W(4),
    .MEM_LAT(MEM_LAT),
    .AUX_TIMEOUT(AUX_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, required %08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: who owns memory, plus a list of cycles-until-return for every outstanding core read.
  typedef enum {M_IDLE, M_FLUSH, M_OWNED, M_HANDBACK} mphase_t;
  mphase_t     m_phase = M_IDLE;
  bit          m_valid = 1'b0;
  bit          m_req_prev = 1'b0;
  bit          m_tmo = 1'b0;
  logic [31:0] m_start_addr = '0;
  int          m_owned = 0;
  int          m_due[$];

  always @(negedge clk) begin
    bit rv;
    bit empty;
    bit start;
    int kept[$];
    if (m_valid) begin
      rv = 1'b0;
      foreach (m_due[i]) if (m_due[i] == 0) rv = 1'b1;
      chk("gnt", bus.core_mem_gnt, (m_phase == M_IDLE) && bus.core_mem_req);
      chk("mem_en", bus.mem_en, (m_phase == M_OWNED) || ((m_phase == M_IDLE) && bus.core_mem_req));
      if (m_phase == M_IDLE) begin
        chk("mem_keep_core", bus.mem_keep, bus.core_mem_keep);
        chk("mem_addr_core", bus.mem_addr, bus.core_mem_addr);
        chk("mem_datai_core", bus.mem_datai, bus.core_mem_datai);
      end else if (m_phase == M_OWNED) begin
        chk("mem_keep_aux", bus.mem_keep, bus.aux_mem_keep);
        chk("mem_addr_aux", bus.mem_addr, bus.aux_mem_addr);
        chk("mem_datai_aux", bus.mem_datai, bus.aux_mem_datai);
      end
      chk("rvalid", bus.core_mem_rvalid, rv);
      chk("aux_en", bus.aux_en, m_phase == M_OWNED);
      chk("aux_busy", bus.aux_busy, m_phase != M_IDLE);
      chk("aux_start_addr", bus.aux_start_addr, m_start_addr);
      chk("aux_timeout", bus.aux_timeout, m_tmo);
      chk("core_datao", bus.core_mem_datao, bus.mem_datao);
      chk("aux_datao", bus.aux_mem_datao, bus.mem_datao);
    end

    empty = (m_due.size() == 0);
    start = bus.aux_req && !m_req_prev;
    m_req_prev = bus.aux_req;
    if (rst) begin
      m_valid      = 1'b1;
      m_phase      = M_IDLE;
      m_due.delete();
      m_start_addr = '0;
      m_tmo        = 1'b0;
      m_owned      = 0;
    end else begin
      kept = {};
      foreach (m_due[i]) if (m_due[i] > 0) kept.push_back(m_due[i] - 1);
      m_due = kept;
      if (m_phase == M_IDLE && bus.core_mem_req && bus.core_mem_keep == 4'h0)
        m_due.push_back(int'(MEM_LAT) - 1);
      m_tmo = 1'b0;
      case (m_phase)
        M_IDLE: if (start) begin
          m_start_addr = bus.aux_req_addr;
          m_phase = M_FLUSH;
        end
        M_FLUSH: if (empty) begin
          m_phase = M_OWNED;
          m_owned = 0;
        end
        M_OWNED: begin
          m_owned++;
          if (bus.aux_done) m_phase = M_HANDBACK;
`ifdef AUX_ARB_TIMEOUT_EN
          else if (m_owned == int'(AUX_TIMEOUT)) begin
            m_phase = M_HANDBACK;
            m_tmo = 1'b1;
          end
`endif
        end
        M_HANDBACK: m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end
  end

  initial begin
    rst = 1'b1;
    bus.core_mem_req = 1'b0;  bus.core_mem_keep = '0;
    bus.core_mem_addr = '0;   bus.core_mem_datai = '0;
    bus.aux_req = 1'b1;       bus.aux_req_addr = '0;
    bus.aux_done = 1'b0;      bus.aux_mem_keep = '0;
    bus.aux_mem_datai = '0;   bus.aux_mem_addr = '0;
    bus.mem_datao = '0;

    // Reset with aux_req held high, then no session until it is re-raised.
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("rst_aux_en", bus.aux_en, 0);
    chk("rst_aux_busy", bus.aux_busy, 0);
    chk("rst_rvalid", bus.core_mem_rvalid, 0);
    repeat (3) begin
      cyc(); #1;
      chk("held_req_idle", bus.aux_busy, 0);
    end

    // Single core read.
    cyc();
    bus.core_mem_req = 1'b1; bus.core_mem_keep = 4'h0;
    bus.core_mem_addr = 32'h100; bus.mem_datao = 32'hDEADBEEF;
    #1;
    chk("rd_mem_addr", bus.mem_addr, 32'h100);
    chk("rd_gnt", bus.core_mem_gnt, 1);
    cyc();
    bus.core_mem_req = 1'b0;
    #1;
    chk("rd_rvalid", bus.core_mem_rvalid, 1);
    chk("rd_datao", bus.core_mem_datao, 32'hDEADBEEF);

    // Session start with a read granted in the request cycle.
    cyc(); bus.aux_req = 1'b0;
    cyc();
    bus.aux_req = 1'b1; bus.aux_req_addr = 32'h2000;
    bus.core_mem_req = 1'b1; bus.core_mem_addr = 32'h40;
    #1;
    chk("start_gnt", bus.core_mem_gnt, 1);
    cyc(); #1;
    chk("drain_busy", bus.aux_busy, 1);
    chk("drain_gnt", bus.core_mem_gnt, 0);
    chk("drain_rvalid", bus.core_mem_rvalid, 1);
    chk("drain_aux_en", bus.aux_en, 0);
    chk("start_addr", bus.aux_start_addr, 32'h2000);
    cyc(); #1;
    chk("drain2_aux_en", bus.aux_en, 0);
    chk("drain2_rvalid", bus.core_mem_rvalid, 0);

    // Engine owns memory.
    cyc();
    bus.aux_mem_addr = 32'h2004; bus.aux_mem_keep = 4'hF; bus.aux_mem_datai = 32'h12345678;
    #1;
    chk("aux_en_on", bus.aux_en, 1);
    chk("aux_mem_addr", bus.mem_addr, 32'h2004);
    chk("aux_mem_keep", bus.mem_keep, 32'hF);
    chk("aux_mem_datai", bus.mem_datai, 32'h12345678);
    chk("aux_mem_en", bus.mem_en, 1);
    chk("aux_core_gnt", bus.core_mem_gnt, 0);
    cyc(); bus.aux_done = 1'b1; #1;
    chk("done_aux_en", bus.aux_en, 1);
    cyc(); bus.aux_done = 1'b0; #1;
    chk("rel_aux_en", bus.aux_en, 0);
    chk("rel_busy", bus.aux_busy, 1);
    chk("rel_mem_en", bus.mem_en, 0);
    chk("rel_gnt", bus.core_mem_gnt, 0);
    cyc(); #1;
    chk("back_gnt", bus.core_mem_gnt, 1);
    chk("back_busy", bus.aux_busy, 0);

    // aux_req still high: no second session until it drops and re-rises.
    cyc(); #1;
    chk("held_no_restart", bus.aux_busy, 0);
    cyc(); bus.aux_req = 1'b0;
    cyc(); bus.aux_req = 1'b1;
    cyc(); #1;
    chk("restart_busy", bus.aux_busy, 1);

    for (int c = 0; c < 4000; c++) begin
      cyc();
      rst = ($urandom_range(0, 299) == 0);
      bus.core_mem_req   = 1'($urandom_range(0, 1));
      bus.core_mem_keep  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      bus.core_mem_addr  = $urandom;
      bus.core_mem_datai = $urandom;
      bus.aux_mem_keep   = 4'($urandom);
      bus.aux_mem_addr   = $urandom;
      bus.aux_mem_datai  = $urandom;
      bus.mem_datao      = $urandom;
      bus.aux_req_addr   = $urandom;
      if ($urandom_range(0, 11) == 0) bus.aux_req = ~bus.aux_req;
      bus.aux_done = ($urandom_range(0, DONE_ODDS) == 0);
    end
    rst = 1'b0;
    cyc();
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
